axis_req_latency_monitor: RTL and testbench
===========================================

Name: axis_req_latency_monitor

Overview:
- Inline AXI-Stream request/response monitor for the RDM datapath. The request path runs from_net to the RDM; the response path runs from the RDM to to_net.
- Passes both streams through combinationally and counts request and response packets.
- Timestamps each request at its first beat and measures per-request latency at the matching response tlast, in FIFO order.
- Can throttle or drain request traffic. Replaces bench-only packet counting with synthesizable in-fabric statistics.

Parameters:
- DATA_WIDTH, 64: tdata width, a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- USER_WIDTH, 64: tuser width.
- TS_WIDTH, 32: timestamp and latency width, in cycles.
- MAX_OUTSTANDING, 16: timestamp FIFO depth, a power of 2, at least 2.
- CNT_WIDTH, 32: packet counter width.

Ports:
- clk_390  in  1  network clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- req_in_tdata/tkeep/tuser/tvalid/tlast  in  DATA_WIDTH/KEEP_WIDTH/USER_WIDTH/1/1  request stream from the network.
- req_in_tready  out  1  ready back to the request source.
- req_out_tdata/tkeep/tuser/tvalid/tlast  out  matching widths  request stream toward the RDM.
- req_out_tready  in  1  ready from the RDM.
- rsp_in_*  in  same set as req_in_*  response stream from the RDM; rsp_in_tready is an output.
- rsp_out_*  out  same set as req_out_*  response stream to the network; rsp_out_tready is an input.
- drain_req  in  1  pulse: stop admitting new requests until all outstanding requests complete.
- drain_busy  out  1  high while a drain is in progress.
- stats_clear  in  1  pulse: clear all statistics.
- nr_sent, nr_received  out  CNT_WIDTH  completed request packets and completed response packets.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- lat_last, lat_min, lat_max  out  TS_WIDTH  latency statistics.
- lat_sum  out  TS_WIDTH+CNT_WIDTH  sum of all recorded latencies.
- err_underflow  out  1  sticky error flag.

Behaviour:
- Reset values:
  - All counters and FIFO pointers are 0; the timestamp counter is 0.
  - lat_last, lat_max and lat_sum are 0; lat_min is all ones.
  - drain_busy and err_underflow are 0.
  - Both in_sop flags are 1.
  - Outputs are driven from the reset-cleared registers.
  - A reset mid-packet discards all in-flight tracking; no partial statistics survive.
- Timestamp counter: free-running, increments every cycle, wraps modulo 2^TS_WIDTH.
- Beat handshake: a beat transfers when tvalid & tready.
- in_sop tracking: in_sop is set after a tlast beat and cleared after a non-last beat. Request and response streams each have their own flag.
- Request gating:
  - block = req_sop & (fifo_full | drain_busy).
  - req_out_tvalid = req_in_tvalid & ~block.
  - req_in_tready = req_out_tready & ~block.
  - tdata, tkeep, tuser and tlast pass straight through.
  - Blocking only applies at start of packet; a packet already in progress is never stalled by this block.
- Request start: on a request beat handshake while req_sop=1, the current timestamp is pushed into the FIFO.
- Request completion: a request beat handshake with tlast increments nr_sent. A single-beat packet both pushes and increments in the same cycle.
- Response path: passes straight through, with no gating.
- Response completion, on a response beat handshake with tlast:
  - nr_received increments.
  - If the FIFO is not empty: pop it; lat = (ts_now - popped) mod 2^TS_WIDTH.
  - Then update lat_last=lat, lat_min=min(lat_min, lat), lat_max=max(lat_max, lat), lat_sum += lat.
  - If the FIFO is empty: set err_underflow; no pop, no latency statistics update; nr_received still increments.
- Simultaneous push and pop: occupancy is unchanged and both operate correctly. When the FIFO is full, a pop in the same cycle still does not unblock a request start in that cycle, because block is computed from the registered full flag.
- Drain:
  - drain_req sets drain_busy on the next edge.
  - drain_busy clears on the first edge where outstanding==0 and req_sop==1.
  - A drain_req arriving while busy is ignored.
  - A drain_req when already idle lasts exactly one cycle.
- stats_clear: resets lat_* (lat_min to all ones), nr_sent, nr_received and err_underflow. It does not affect the FIFO, outstanding or drain state. If it coincides with an update, the clear wins.
- Latency: measured from the first request beat to the response last beat, both on their handshake cycles. A single beat with a 1-cycle turnaround gives lat=1.

Optional Feature:
- Macro: LAT_HIST_EN.
- Defined:
  - Adds output lat_hist, width 8*CNT_WIDTH, holding 8 bucket counters.
  - Bucket index = floor(log2(lat)), clamped to 0..7; lat of 0 or 1 goes to bucket 0.
  - The selected bucket increments on every statistics update.
  - Buckets are cleared by sys_rst and by stats_clear.
- Not defined: no histogram logic and no lat_hist port.

Test Plan:
1. Reset, then one 3-beat request; the RDM model returns a 2-beat response 10 cycles after the request's last beat. Required: nr_sent=1, nr_received=1, lat_last=lat_min=lat_max=lat_sum=12, outstanding returns to 0.
2. 20 single-beat requests with response tready held low; MAX_OUTSTANDING=16. Required: outstanding saturates at 16 and req_in_tready goes low only at SOP. After 4 responses complete, exactly 4 more requests are accepted.
3. Backpressure on req_out_tready mid-packet while the FIFO is full. Required: the packet completes with no block-induced stall and no data loss, and output data matches input byte-for-byte including tkeep.
4. Response tlast with an empty FIFO. Required: err_underflow=1 and stays set, lat_* unchanged, nr_received increments. stats_clear then returns err_underflow to 0 and lat_min to all ones.
5. Three requests outstanding, then pulse drain_req. Required: drain_busy=1 and a new request is held at SOP. drain_busy drops on the edge after the third response tlast, and the held request passes on the next cycle.
6. With LAT_HIST_EN defined, latencies 1, 5, 300 are recorded. Required: bucket0=1, bucket2=1, bucket7=1, all other buckets 0.

Source files
------------

// File: rtl/axis_req_latency_monitor_if.sv
// AXI-Stream bundle for the latency monitor.
// Master drives the payload and tvalid; slave drives tready.
interface axis_req_latency_monitor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_req_latency_monitor.sv
// Inline request/response AXI-Stream monitor: passthrough, packet counts, FIFO-ordered latency.
// Define LAT_HIST_EN to add the 8-bucket log2 latency histogram on lat_hist.
module axis_req_latency_monitor #(
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH/8,
  parameter int USER_WIDTH      = 64,
  parameter int TS_WIDTH        = 32,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 32,
  localparam int AW             = $clog2(MAX_OUTSTANDING)
) (
  input  logic                             clk_390,
  input  logic                             sys_rst,
  axis_req_latency_monitor_if.slave        req_in,
  axis_req_latency_monitor_if.master       req_out,
  axis_req_latency_monitor_if.slave        rsp_in,
  axis_req_latency_monitor_if.master       rsp_out,
  input  logic                             drain_req,
  output logic                             drain_busy,
  input  logic                             stats_clear,
  output logic [CNT_WIDTH-1:0]             nr_sent,
  output logic [CNT_WIDTH-1:0]             nr_received,
  output logic [AW:0]                      outstanding,
  output logic [TS_WIDTH-1:0]              lat_last,
  output logic [TS_WIDTH-1:0]              lat_min,
  output logic [TS_WIDTH-1:0]              lat_max,
  output logic [TS_WIDTH+CNT_WIDTH-1:0]    lat_sum,
  output logic                             err_underflow
`ifdef LAT_HIST_EN
  ,
  output logic [8*CNT_WIDTH-1:0]           lat_hist
`endif
);

  if (DATA_WIDTH % 8 != 0 || KEEP_WIDTH != DATA_WIDTH/8)
    $error("DATA_WIDTH must be a multiple of 8 with KEEP_WIDTH = DATA_WIDTH/8");
  if (MAX_OUTSTANDING < 2 || (1 << AW) != MAX_OUTSTANDING)
    $error("MAX_OUTSTANDING must be a power of 2, at least 2");
  if (USER_WIDTH < 1 || TS_WIDTH < 1 || CNT_WIDTH < 1)
    $error("widths must be positive");

  typedef enum logic {D_IDLE, D_BUSY} drain_state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(MAX_OUTSTANDING);

  logic [TS_WIDTH-1:0] ts;
  logic                req_sop, rsp_sop;
  logic [TS_WIDTH-1:0] ts_mem [MAX_OUTSTANDING];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         cnt;
  logic                full, empty, block;
  logic                req_hs, rsp_hs, rsp_done, push, pop, underflow;
  logic [TS_WIDTH-1:0] lat;
  drain_state_t        d_state, d_next;

  // full comes from the registered count, so a same-cycle pop never unblocks a start
  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);
  assign block = req_sop & (full | drain_busy);

  assign req_out.tvalid = req_in.tvalid & ~block;
  assign req_in.tready  = req_out.tready & ~block;
  assign req_out.tdata  = req_in.tdata;
  assign req_out.tkeep  = req_in.tkeep;
  assign req_out.tuser  = req_in.tuser;
  assign req_out.tlast  = req_in.tlast;

  assign rsp_out.tvalid = rsp_in.tvalid;
  assign rsp_in.tready  = rsp_out.tready;
  assign rsp_out.tdata  = rsp_in.tdata;
  assign rsp_out.tkeep  = rsp_in.tkeep;
  assign rsp_out.tuser  = rsp_in.tuser;
  assign rsp_out.tlast  = rsp_in.tlast;

  assign req_hs    = req_in.tvalid & req_in.tready;
  assign rsp_hs    = rsp_in.tvalid & rsp_in.tready;
  assign rsp_done  = rsp_hs & rsp_in.tlast;
  assign push      = req_hs & req_sop;
  assign pop       = rsp_done & ~empty;
  assign underflow = rsp_done & empty;
  assign lat       = ts - ts_mem[rd_ptr];

  always_ff @(posedge clk_390) begin
    if (sys_rst) begin
      ts      <= '0;
      req_sop <= 1'b1;
      rsp_sop <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      if (req_hs) req_sop <= req_in.tlast;
      if (rsp_hs) rsp_sop <= rsp_in.tlast;
      if (push)   wr_ptr  <= wr_ptr + AW'(1);
      if (pop)    rd_ptr  <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_390) begin
    if (push) ts_mem[wr_ptr] <= ts;
  end

  always_ff @(posedge clk_390) begin
    if (sys_rst) d_state <= D_IDLE;
    else         d_state <= d_next;
  end

  // Drain holds new starts until every tracked request has its response
  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE:  if (drain_req) d_next = D_BUSY;
      D_BUSY:  if (empty && req_sop) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  assign drain_busy  = (d_state == D_BUSY);
  assign outstanding = cnt;

  always_ff @(posedge clk_390) begin
    if (sys_rst || stats_clear) begin
      nr_sent       <= '0;
      nr_received   <= '0;
      lat_last      <= '0;
      lat_min       <= '1;
      lat_max       <= '0;
      lat_sum       <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (req_hs && req_in.tlast) nr_sent     <= nr_sent + CNT_WIDTH'(1);
      if (rsp_done)               nr_received <= nr_received + CNT_WIDTH'(1);
      if (underflow)              err_underflow <= 1'b1;
      if (pop) begin
        lat_last <= lat;
        if (lat < lat_min) lat_min <= lat;
        if (lat > lat_max) lat_max <= lat;
        lat_sum <= lat_sum + {{CNT_WIDTH{1'b0}}, lat};
      end
    end
  end

`ifdef LAT_HIST_EN
  logic [7:0][CNT_WIDTH-1:0] hist;
  logic [2:0]                bkt;

  // floor(log2(lat)) clamped to 7; 0 and 1 both land in bucket 0
  always_comb begin
    bkt = '0;
    for (int i = 1; i < 8; i++)
      if (lat >= (TS_WIDTH'(1) << i)) bkt = 3'(i);
  end

  always_ff @(posedge clk_390) begin
    if (sys_rst || stats_clear) hist <= '0;
    else if (pop) hist[bkt] <= hist[bkt] + CNT_WIDTH'(1);
  end

  assign lat_hist = hist;
`endif

endmodule

// File: tb/tb_axis_req_latency_monitor.sv
// Randomized + directed bench for axis_req_latency_monitor with a queue-based reference model.
// Build with LAT_HIST_EN defined to also check the histogram.
module tb_axis_req_latency_monitor;
  localparam int DW = 64, KW = 8, UW = 64, TW = 32, MO = 16, CW = 32;

  logic clk_390 = 1'b0;
  logic sys_rst = 1'b1;
  logic drain_req = 1'b0, stats_clear = 1'b0;
  logic drain_busy, err_underflow;
  logic [CW-1:0] nr_sent, nr_received;
  logic [4:0] outstanding;
  logic [TW-1:0] lat_last, lat_min, lat_max;
  logic [TW+CW-1:0] lat_sum;
`ifdef LAT_HIST_EN
  logic [8*CW-1:0] lat_hist;
`endif

  axis_req_latency_monitor_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) req_in ();
  axis_req_latency_monitor_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) req_out ();
  axis_req_latency_monitor_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) rsp_in ();
  axis_req_latency_monitor_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) rsp_out ();

  axis_req_latency_monitor #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
    .TS_WIDTH(TW), .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)
  ) dut (
    .clk_390(clk_390), .sys_rst(sys_rst),
    .req_in(req_in), .req_out(req_out), .rsp_in(rsp_in), .rsp_out(rsp_out),
    .drain_req(drain_req), .drain_busy(drain_busy), .stats_clear(stats_clear),
    .nr_sent(nr_sent), .nr_received(nr_received), .outstanding(outstanding),
    .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
    .err_underflow(err_underflow)
`ifdef LAT_HIST_EN
    , .lat_hist(lat_hist)
`endif
  );

  always #5 clk_390 = ~clk_390;

  int vectors = 0, miscompares = 0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: occupancy is a queue of start cycles ----------------
  longint     m_q[$];
  longint     m_cyc;
  bit         m_ready = 0;
  bit         m_rsop, m_ssop, m_drain, m_err;
  logic [CW-1:0] m_sent, m_rcvd;
  logic [TW-1:0] m_last, m_min, m_max;
  logic [TW+CW-1:0] m_sum;
  logic [CW-1:0] m_hist[8];

  function automatic void model_clear_stats();
    m_sent = '0; m_rcvd = '0; m_last = '0; m_min = '1; m_max = '0; m_sum = '0; m_err = 0;
    for (int i = 0; i < 8; i++) m_hist[i] = '0;
  endfunction

  always @(negedge clk_390) begin
    bit blk, rhs, slast;
    int occ;
    longint t, v;
    logic [TW-1:0] l;
    int b;
    if (sys_rst) begin
      m_q.delete(); m_cyc = 0; m_rsop = 1; m_ssop = 1; m_drain = 0;
      model_clear_stats();
      m_ready = 1;
    end else if (m_ready) begin
      occ = m_q.size();
      blk = m_rsop && (occ == MO || m_drain);
      chk("req_in_tready",  req_in.tready,  req_out.tready && !blk);
      chk("req_out_tvalid", req_out.tvalid, req_in.tvalid && !blk);
      chk("req_pass_data",  {req_out.tdata, req_out.tkeep, req_out.tlast},
                            {req_in.tdata,  req_in.tkeep,  req_in.tlast});
      chk("req_pass_user",  req_out.tuser, req_in.tuser);
      chk("rsp_pass",       {rsp_out.tdata, rsp_out.tkeep, rsp_out.tlast, rsp_out.tvalid, rsp_in.tready},
                            {rsp_in.tdata,  rsp_in.tkeep,  rsp_in.tlast,  rsp_in.tvalid,  rsp_out.tready});
      chk("rsp_pass_user",  rsp_out.tuser, rsp_in.tuser);
      chk("outstanding",    outstanding, occ);
      chk("drain_busy",     drain_busy, m_drain);
      chk("nr_sent",        nr_sent, m_sent);
      chk("nr_received",    nr_received, m_rcvd);
      chk("lat_last",       lat_last, m_last);
      chk("lat_min",        lat_min, m_min);
      chk("lat_max",        lat_max, m_max);
      chk("lat_sum",        lat_sum, m_sum);
      chk("err_underflow",  err_underflow, m_err);
`ifdef LAT_HIST_EN
      for (int i = 0; i < 8; i++) chk($sformatf("lat_hist%0d", i), lat_hist[i*CW +: CW], m_hist[i]);
`endif
      rhs   = req_in.tvalid && req_out.tready && !blk;
      slast = rsp_in.tvalid && rsp_out.tready && rsp_in.tlast;
      if (m_drain) begin
        if (occ == 0 && m_rsop) m_drain = 0;
      end else if (drain_req) m_drain = 1;
      if (slast && occ == 0) m_err = 1;
      if (slast && occ != 0) begin
        t = m_q.pop_front();
        l = TW'(m_cyc - t);
        m_last = l;
        if (l < m_min) m_min = l;
        if (l > m_max) m_max = l;
        m_sum = m_sum + l;
        v = l; b = 0;
        while (v > 1) begin v = v >> 1; b++; end
        if (b > 7) b = 7;
        m_hist[b] = m_hist[b] + 1;
      end
      if (rhs && m_rsop) m_q.push_back(m_cyc);
      if (rhs && req_in.tlast) m_sent = m_sent + 1;
      if (slast) m_rcvd = m_rcvd + 1;
      if (stats_clear) model_clear_stats();
      if (rhs) m_rsop = req_in.tlast;
      if (rsp_in.tvalid && rsp_out.tready) m_ssop = rsp_in.tlast;
      m_cyc++;
    end
  end

  // ---------------- driver helpers ----------------
  logic hreq, hrsp;
  bit cap = 0;
  logic [DW-1:0] cap_d[$], exp_d[$];
  logic [KW-1:0] cap_k[$], exp_k[$];

  // hreq/hrsp report the handshakes at the edge this tick crosses
  task automatic tick();
    @(negedge clk_390);
    hreq = req_in.tvalid && req_in.tready;
    hrsp = rsp_in.tvalid && rsp_in.tready;
    if (cap && req_out.tvalid && req_out.tready) begin
      cap_d.push_back(req_out.tdata); cap_k.push_back(req_out.tkeep);
    end
    @(posedge clk_390); #1;
  endtask

  task automatic req_beat(input bit last);
    req_in.tvalid = 1; req_in.tlast = last;
    req_in.tdata = {$urandom, $urandom}; req_in.tkeep = KW'($urandom); req_in.tuser = {$urandom, $urandom};
  endtask

  task automatic rsp_beat(input bit last);
    rsp_in.tvalid = 1; rsp_in.tlast = last;
    rsp_in.tdata = {$urandom, $urandom}; rsp_in.tkeep = KW'($urandom); rsp_in.tuser = {$urandom, $urandom};
  endtask

  task automatic until_req(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!hreq && n < 100);
    chk(nm, hreq, 1'b1);
  endtask

  task automatic until_rsp(input string nm);
    int n = 0;
    do begin tick(); n++; end while (!hrsp && n < 100);
    chk(nm, hrsp, 1'b1);
  endtask

  // one single-beat request, response exactly L cycles after it
  task automatic rec_lat(input int L);
    req_out.tready = 1; rsp_out.tready = 1;
    req_beat(1); tick(); chk("lat_req_hs", hreq, 1'b1);
    req_in.tvalid = 0;
    repeat (L - 1) tick();
    rsp_beat(1); tick(); chk("lat_rsp_hs", hrsp, 1'b1);
    rsp_in.tvalid = 0;
    chk("lat_value", lat_last, L);
  endtask

  task automatic run_random(input int cycles);
    int rq_left = 0, rs_left = 0, req_done = 0, rsp_start = 0;
    for (int c = 0; c < cycles; c++) begin
      if (c == cycles / 2) begin
        sys_rst = 1; req_in.tvalid = 0; rsp_in.tvalid = 0; drain_req = 0; stats_clear = 0;
        rq_left = 0; rs_left = 0; req_done = 0; rsp_start = 0;
        tick(); tick(); sys_rst = 0;
      end
      req_out.tready = ($urandom_range(99) < 80);
      rsp_out.tready = ($urandom_range(99) < 70);
      drain_req      = ($urandom_range(199) == 0);
      stats_clear    = ($urandom_range(499) == 0);
      if (!req_in.tvalid && $urandom_range(99) < 40) begin
        rq_left = $urandom_range(1, 4); req_beat(rq_left == 1);
      end
      if (!rsp_in.tvalid && (rsp_start < req_done || $urandom_range(299) == 0) && $urandom_range(99) < 40) begin
        rs_left = $urandom_range(1, 3); rsp_start++; rsp_beat(rs_left == 1);
      end
      tick();
      if (hreq) begin
        if (req_in.tlast) req_done++;
        rq_left--;
        if (rq_left > 0) req_beat(rq_left == 1); else req_in.tvalid = 0;
      end
      if (hrsp) begin
        rs_left--;
        if (rs_left > 0) rsp_beat(rs_left == 1); else rsp_in.tvalid = 0;
      end
    end
    drain_req = 0; stats_clear = 0; req_in.tvalid = 0; rsp_in.tvalid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, pops, n;
    req_in.tvalid = 0; req_in.tlast = 0; req_in.tdata = '0; req_in.tkeep = '0; req_in.tuser = '0;
    rsp_in.tvalid = 0; rsp_in.tlast = 0; rsp_in.tdata = '0; rsp_in.tkeep = '0; rsp_in.tuser = '0;
    req_out.tready = 1; rsp_out.tready = 1;
    repeat (3) tick();
    sys_rst = 0;

    // reset state
    chk("rst_nr_sent", nr_sent, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_lat_min", lat_min, 32'hFFFF_FFFF);
    chk("rst_lat_sum", lat_sum, 0);
    chk("rst_flags", {drain_busy, err_underflow}, 2'b00);
    chk("rst_req_tready", req_in.tready, 1'b1);

    // 1: 3-beat request, 2-beat response ending 10 cycles after the last request beat
    for (int b = 0; b < 3; b++) begin req_beat(b == 2); tick(); chk("t1_req_hs", hreq, 1'b1); end
    req_in.tvalid = 0;
    repeat (8) tick();
    rsp_beat(0); tick(); rsp_beat(1); tick(); rsp_in.tvalid = 0;
    chk("t1_nr_sent", nr_sent, 1);
    chk("t1_nr_received", nr_received, 1);
    chk("t1_lat", {lat_last, lat_min, lat_max}, {32'd12, 32'd12, 32'd12});
    chk("t1_lat_sum", lat_sum, 12);
    chk("t1_outstanding", outstanding, 0);

    // 2: fill the FIFO with response side stalled
    rsp_out.tready = 0; acc = 0;
    req_beat(1);
    repeat (25) begin tick(); if (hreq) acc++; req_beat(1); end
    chk("t2_accepted", acc, 16);
    chk("t2_outstanding", outstanding, 16);
    chk("t2_tready_low", req_in.tready, 1'b0);
    rsp_out.tready = 1; rsp_beat(1); pops = 0;
    repeat (12) begin
      tick();
      if (hreq) acc++;
      if (hrsp) pops++;
      req_beat(1);
      if (pops == 4) rsp_in.tvalid = 0;
    end
    req_in.tvalid = 0;
    chk("t2_pops", pops, 4);
    chk("t2_accepted_after", acc, 20);
    chk("t2_outstanding_after", outstanding, 16);

    // 3: fill the last slot with a 4-beat packet under random backpressure
    rsp_beat(1); until_rsp("t3_pop"); rsp_in.tvalid = 0;
    cap = 1;
    for (int b = 0; b < 4; b++) begin
      req_beat(b == 3); exp_d.push_back(req_in.tdata); exp_k.push_back(req_in.tkeep);
      n = 0;
      do begin
        req_out.tready = $urandom_range(0, 1);
        tick(); n++;
        if (req_out.tready) chk("t3_nostall", hreq, 1'b1);
      end while (!hreq && n < 100);
      chk("t3_beat_hs", hreq, 1'b1);
    end
    req_in.tvalid = 0; req_out.tready = 1; tick(); cap = 0;
    chk("t3_beats", cap_d.size(), 4);
    for (int b = 0; b < 4 && b < cap_d.size(); b++) begin
      chk("t3_data", cap_d[b], exp_d[b]);
      chk("t3_keep", cap_k[b], exp_k[b]);
    end
    chk("t3_outstanding", outstanding, 16);
    rsp_beat(1);
    for (int i = 0; i < 16; i++) until_rsp("t3_drain_rsp");
    rsp_in.tvalid = 0;
    chk("t3_empty", outstanding, 0);

    // 4: response with nothing outstanding
    chk("t4_pre_rcvd", nr_received, 22);
    rsp_beat(1); tick(); rsp_in.tvalid = 0;
    chk("t4_err", err_underflow, 1'b1);
    chk("t4_rcvd", nr_received, 23);
    chk("t4_sent", nr_sent, 22);
    repeat (3) tick();
    chk("t4_err_sticky", err_underflow, 1'b1);
    stats_clear = 1; tick(); stats_clear = 0;
    chk("t4_clr_err", err_underflow, 1'b0);
    chk("t4_clr_min", lat_min, 32'hFFFF_FFFF);
    chk("t4_clr_cnt", {nr_sent, nr_received}, 64'd0);

    // 5: drain with three outstanding
    for (int i = 0; i < 3; i++) begin req_beat(1); until_req("t5_req"); end
    req_in.tvalid = 0;
    drain_req = 1; tick(); drain_req = 0;
    chk("t5_busy", drain_busy, 1'b1);
    chk("t5_outstanding", outstanding, 3);
    req_beat(1);
    repeat (3) begin tick(); chk("t5_held", hreq, 1'b0); end
    rsp_beat(1);
    for (int i = 0; i < 3; i++) begin tick(); chk("t5_rsp", hrsp, 1'b1); chk("t5_held_rsp", hreq, 1'b0); end
    rsp_in.tvalid = 0;
    chk("t5_still_busy", drain_busy, 1'b1);
    chk("t5_zero", outstanding, 0);
    tick(); chk("t5_held_last", hreq, 1'b0);
    chk("t5_idle", drain_busy, 1'b0);
    tick(); chk("t5_pass", hreq, 1'b1);
    req_in.tvalid = 0;
    rsp_beat(1); until_rsp("t5_cleanup"); rsp_in.tvalid = 0;
    tick();

    // 6: latencies 1, 5, 300
    stats_clear = 1; tick(); stats_clear = 0;
    rec_lat(1); rec_lat(5); rec_lat(300);
    chk("t6_min_max", {lat_min, lat_max}, {32'd1, 32'd300});
    chk("t6_sum", lat_sum, 306);
`ifdef LAT_HIST_EN
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6_bucket%0d", i), lat_hist[i*CW +: CW], (i == 0 || i == 2 || i == 7) ? 1 : 0);
`endif

    run_random(4000);
    rsp_out.tready = 1; req_out.tready = 1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
